riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, between both cache refill/writeback paths and the single shared main-memory port.
- Accepts whole-line transfer requests from each cache, arbitrates between them and serializes each line into BEAT_W-wide beats on a ready-handshaked memory port.
- Returns the assembled line and a one-cycle done pulse to the requesting cache.
- Icache path is read-only; dcache path supports line read (refill) and line write (writeback).

Parameters:
- LINE_W, 128, cache line width in bits; must be a multiple of BEAT_W.
- BEAT_W, 64, memory data beat width in bits.
- ADDR_W, 64, physical address width.
- BEATS (localparam), LINE_W/BEAT_W, beats per line.

Ports:
- i_riscv_arb_clk  in  1  clock; all logic is rising-edge.
- i_riscv_arb_rst  in  1  asynchronous, active-low reset.
- i_riscv_arb_ic_req  in  1  icache line-read request; held high until done.
- i_riscv_arb_ic_addr  in  ADDR_W  icache miss address.
- o_riscv_arb_ic_rdata  out  LINE_W  line returned to the icache.
- o_riscv_arb_ic_done  out  1  one-cycle completion pulse to the icache.
- i_riscv_arb_dc_req  in  1  dcache request; held high until done.
- i_riscv_arb_dc_we  in  1  1 = line write (writeback), 0 = line read.
- i_riscv_arb_dc_addr  in  ADDR_W  dcache line address.
- i_riscv_arb_dc_wdata  in  LINE_W  writeback line.
- o_riscv_arb_dc_rdata  out  LINE_W  line returned to the dcache.
- o_riscv_arb_dc_done  out  1  one-cycle completion pulse to the dcache.
- o_riscv_arb_mem_req  out  1  beat request to memory.
- o_riscv_arb_mem_we  out  1  beat is a write.
- o_riscv_arb_mem_addr  out  ADDR_W  beat byte address.
- o_riscv_arb_mem_wdata  out  BEAT_W  write beat data.
- i_riscv_arb_mem_ready  in  1  beat accepted (write) or read data valid.
- i_riscv_arb_mem_rdata  in  BEAT_W  read beat data; valid when ready is high.

Behaviour:
- Reset (async, rst low):
  - State goes to IDLE; beat counter = 0.
  - All outputs and both rdata line registers are 0.
  - A transfer in flight is abandoned; no done pulse is issued.
- States: IDLE, IC_RD, DC_RD, DC_WR, RESP.
- IDLE:
  - dc_req has fixed priority over ic_req.
  - On grant, register the owner, the line-aligned base address (addr with low log2(LINE_W/8) bits cleared) and, for DC_WR, dc_wdata.
  - Clear the beat counter and move to DC_WR, DC_RD or IC_RD.
  - No mem_req is driven in IDLE.
- Transfer states:
  - mem_req = 1; mem_we = 1 only in DC_WR.
  - mem_addr = base + beat*(BEAT_W/8).
  - mem_wdata = registered wdata slice [beat*BEAT_W +: BEAT_W].
  - A beat completes in any cycle where mem_req && mem_ready.
  - While ready is low, addr, we and wdata are held stable.
  - Read beats write mem_rdata into the owner's rdata register at slice [beat*BEAT_W +: BEAT_W]. Beat 0 is the least significant slice.
  - The counter increments per completed beat. Completion of beat BEATS-1 moves to RESP.
- RESP:
  - Exactly one cycle: the owner's done = 1 (combinational from state and owner); mem_req = 0.
  - Next state is IDLE.
- rdata registers hold their value until that owner's next read transfer overwrites beats.
  - dc_rdata is not modified by DC_WR.
  - Non-owner rdata is never touched.
- Latency:
  - Request sampled in IDLE at cycle 0; beats start at cycle 1.
  - With ready tied high, done occurs at cycle BEATS+1.
  - Idle gap between back-to-back transfers: RESP plus one IDLE cycle.
- Handshake rules for requesters:
  - req stays high with stable addr/we/wdata until done.
  - req must be low in the cycle after done, unless a new request is intended.
- Boundary conditions:
  - req dropped mid-transfer: the transfer still completes and done is still pulsed.
  - Both reqs high in IDLE: dcache is granted; icache is served after the dcache RESP if still requesting.
  - New request arriving during a transfer: it waits; it is sampled only in IDLE.
  - Address already line-aligned: unchanged. Unaligned address: low bits are ignored.
  - Beat counter width is clog2(BEATS), minimum 1 bit; no wrap occurs inside a transfer.

Test Plan:
- Reset mid-transfer: assert dc read, complete 1 beat, pull rst low -> next cycle all outputs 0, dc_rdata = 0; after rst release with no req, mem_req stays 0 and no done pulse ever appears.
- Icache read, ready tied 1, ic_addr=0x1008, rdata beats 0xAAAA_0000, 0xBBBB_0001 -> mem_addr 0x1000 then 0x1008; ic_done at cycle 3; ic_rdata = {64'hBBBB_0001, 64'hAAAA_0000}.
- Dcache writeback, dc_addr=0x2000, wdata=128'h1111_2222_3333_4444_5555_6666_7777_8888, ready low 3 cycles before each beat -> mem_we=1; beats 0x5555_6666_7777_8888 @0x2000 then 0x1111_2222_3333_4444 @0x2008 held stable while stalled; dc_done once; dc_rdata unchanged.
- ic_req and dc_req rise in the same cycle -> dcache transfer first with its dc_done; then icache beats begin two cycles later and ic_done follows; exactly one done pulse per requester.
- ic_req dropped after beat 0 of a read -> beat 1 still issued; ic_done still pulses; no further mem_req afterwards.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter_if
// Brief    : Cache-side request/response and memory beat-port signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_mem_arbiter_if #(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 64
);
  logic              i_riscv_arb_ic_req;
  logic [ADDR_W-1:0] i_riscv_arb_ic_addr;
  logic [LINE_W-1:0] o_riscv_arb_ic_rdata;
  logic              o_riscv_arb_ic_done;
  logic              i_riscv_arb_dc_req;
  logic              i_riscv_arb_dc_we;
  logic [ADDR_W-1:0] i_riscv_arb_dc_addr;
  logic [LINE_W-1:0] i_riscv_arb_dc_wdata;
  logic [LINE_W-1:0] o_riscv_arb_dc_rdata;
  logic              o_riscv_arb_dc_done;
  logic              o_riscv_arb_mem_req;
  logic              o_riscv_arb_mem_we;
  logic [ADDR_W-1:0] o_riscv_arb_mem_addr;
  logic [BEAT_W-1:0] o_riscv_arb_mem_wdata;
  logic              i_riscv_arb_mem_ready;
  logic [BEAT_W-1:0] i_riscv_arb_mem_rdata;

  // Caches and memory together form the environment around the arbiter.
  modport master (
    output i_riscv_arb_ic_req, i_riscv_arb_ic_addr,
    output i_riscv_arb_dc_req, i_riscv_arb_dc_we, i_riscv_arb_dc_addr, i_riscv_arb_dc_wdata,
    output i_riscv_arb_mem_ready, i_riscv_arb_mem_rdata,
    input  o_riscv_arb_ic_rdata, o_riscv_arb_ic_done,
    input  o_riscv_arb_dc_rdata, o_riscv_arb_dc_done,
    input  o_riscv_arb_mem_req, o_riscv_arb_mem_we, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
  );

  modport slave (
    input  i_riscv_arb_ic_req, i_riscv_arb_ic_addr,
    input  i_riscv_arb_dc_req, i_riscv_arb_dc_we, i_riscv_arb_dc_addr, i_riscv_arb_dc_wdata,
    input  i_riscv_arb_mem_ready, i_riscv_arb_mem_rdata,
    output o_riscv_arb_ic_rdata, o_riscv_arb_ic_done,
    output o_riscv_arb_dc_rdata, o_riscv_arb_dc_done,
    output o_riscv_arb_mem_req, o_riscv_arb_mem_we, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Brief    : Icache/dcache line arbiter serializing lines into memory beats.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 64
) (
  input  wire logic          i_riscv_arb_clk,
  input  wire logic          i_riscv_arb_rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = BEAT_W / 8;

  localparam logic [ADDR_W-1:0] c_line_mask = ~ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IC_RD = 3'd1,
    S_DC_RD = 3'd2,
    S_DC_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_owner_dc;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_beat;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_ic_rdata;
  logic [LINE_W-1:0] r_dc_rdata;

  logic              w_xfer;
  logic              w_last;
  int                w_lo;

  assign w_xfer = (r_state == S_IC_RD) || (r_state == S_DC_RD) || (r_state == S_DC_WR);
  assign w_last = (r_beat == c_last_beat);
  assign w_lo   = int'(r_beat) * BEAT_W;

  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
    if (!i_riscv_arb_rst) begin
      r_state    <= S_IDLE;
      r_owner_dc <= 1'b0;
      r_base     <= '0;
      r_beat     <= '0;
      r_wdata    <= '0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          // Dcache wins ties so dirty evictions never starve behind fetches.
          if (bus.i_riscv_arb_dc_req) begin
            r_owner_dc <= 1'b1;
            r_base     <= bus.i_riscv_arb_dc_addr & c_line_mask;
            if (bus.i_riscv_arb_dc_we) begin
              r_wdata <= bus.i_riscv_arb_dc_wdata;
              r_state <= S_DC_WR;
            end else begin
              r_state <= S_DC_RD;
            end
          end else if (bus.i_riscv_arb_ic_req) begin
            r_owner_dc <= 1'b0;
            r_base     <= bus.i_riscv_arb_ic_addr & c_line_mask;
            r_state    <= S_IC_RD;
          end
        end
        S_IC_RD, S_DC_RD, S_DC_WR: begin
          if (bus.i_riscv_arb_mem_ready) begin
            if (r_state == S_IC_RD) begin
              r_ic_rdata[w_lo +: BEAT_W] <= bus.i_riscv_arb_mem_rdata;
            end
            if (r_state == S_DC_RD) begin
              r_dc_rdata[w_lo +: BEAT_W] <= bus.i_riscv_arb_mem_rdata;
            end
            if (w_last) begin
              r_state <= S_RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat-port outputs are zeroed outside transfer states so idle/reset is clean.
  assign bus.o_riscv_arb_mem_req   = w_xfer;
  assign bus.o_riscv_arb_mem_we    = (r_state == S_DC_WR);
  assign bus.o_riscv_arb_mem_addr  = w_xfer ? (r_base + ADDR_W'(r_beat) * ADDR_W'(BEAT_BYTES)) : '0;
  assign bus.o_riscv_arb_mem_wdata = (r_state == S_DC_WR) ? r_wdata[w_lo +: BEAT_W] : '0;

  assign bus.o_riscv_arb_ic_done  = (r_state == S_RESP) && !r_owner_dc;
  assign bus.o_riscv_arb_dc_done  = (r_state == S_RESP) && r_owner_dc;
  assign bus.o_riscv_arb_ic_rdata = r_ic_rdata;
  assign bus.o_riscv_arb_dc_rdata = r_dc_rdata;
endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_arbiter
// Brief    : Directed scoreboard bench for riscv_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;
  localparam int LINE_W = 128;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) bus ();

  riscv_mem_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .i_riscv_arb_clk (clk),
    .i_riscv_arb_rst (rst_n),
    .bus             (bus)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } beat_t;

  beat_t beat_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stall_cfg = 0;
  int stall_left = 0;
  int ic_done_cnt = 0;
  int dc_done_cnt = 0;
  int ic_done_cyc = 0;
  int dc_done_cyc = 0;
  int c0 = 0;
  int c1 = 0;
  logic [127:0] exp_dc_line = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [63:0] a, input logic we, input logic [63:0] wd, input logic [63:0] rd);
    beat_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd;
    beat_q.push_back(e);
  endtask

  // One cycle of the memory model: sample outputs on the falling edge, check
  // any presented beat against the scoreboard head and decide ready.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    cyc++;
    if (bus.o_riscv_arb_ic_done === 1'b1) begin ic_done_cnt++; ic_done_cyc = cyc; end
    if (bus.o_riscv_arb_dc_done === 1'b1) begin dc_done_cnt++; dc_done_cyc = cyc; end
    bus.i_riscv_arb_mem_ready = 1'b0;
    if (bus.o_riscv_arb_mem_req === 1'b1) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", bus.o_riscv_arb_mem_req, 1'b0);
      end else begin
        e = beat_q[0];
        chk("beat_addr", bus.o_riscv_arb_mem_addr, e.addr);
        chk("beat_we", bus.o_riscv_arb_mem_we, e.we);
        if (e.we) chk("beat_wdata", bus.o_riscv_arb_mem_wdata, e.wdata);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.i_riscv_arb_mem_ready = 1'b1;
          bus.i_riscv_arb_mem_rdata = e.rdata;
          void'(beat_q.pop_front());
          stall_left = stall_cfg;
        end
      end
    end
  endtask

  task automatic wait_done(input bit dc, input int bound, input string tag);
    int start;
    bit seen;
    start = dc ? dc_done_cnt : ic_done_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if ((dc ? dc_done_cnt : ic_done_cnt) != start) seen = 1'b1;
    end
    if (!seen) chk(tag, dc ? dc_done_cnt : ic_done_cnt, start + 1);
  endtask

  initial begin
    bus.i_riscv_arb_ic_req    = 1'b0;
    bus.i_riscv_arb_ic_addr   = '0;
    bus.i_riscv_arb_dc_req    = 1'b0;
    bus.i_riscv_arb_dc_we     = 1'b0;
    bus.i_riscv_arb_dc_addr   = '0;
    bus.i_riscv_arb_dc_wdata  = '0;
    bus.i_riscv_arb_mem_ready = 1'b0;
    bus.i_riscv_arb_mem_rdata = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_req", bus.o_riscv_arb_mem_req, 1'b0);
    chk("rst_mem_we", bus.o_riscv_arb_mem_we, 1'b0);
    chk("rst_mem_addr", bus.o_riscv_arb_mem_addr, '0);
    chk("rst_mem_wdata", bus.o_riscv_arb_mem_wdata, '0);
    chk("rst_ic_done", bus.o_riscv_arb_ic_done, 1'b0);
    chk("rst_dc_done", bus.o_riscv_arb_dc_done, 1'b0);
    chk("rst_ic_rdata", bus.o_riscv_arb_ic_rdata, '0);
    chk("rst_dc_rdata", bus.o_riscv_arb_dc_rdata, '0);
    rst_n = 1'b1;

    // Reset in the middle of a dcache read, after one beat has landed
    tick();
    bus.i_riscv_arb_dc_req  = 1'b1;
    bus.i_riscv_arb_dc_we   = 1'b0;
    bus.i_riscv_arb_dc_addr = 64'h3000;
    push_beat(64'h3000, 1'b0, '0, 64'hDEAD_BEEF_0000_0001);
    push_beat(64'h3008, 1'b0, '0, 64'hDEAD_BEEF_0000_0002);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_riscv_arb_dc_req    = 1'b0;
    bus.i_riscv_arb_mem_ready = 1'b0;
    #1;
    chk("midrst_mem_req", bus.o_riscv_arb_mem_req, 1'b0);
    chk("midrst_mem_addr", bus.o_riscv_arb_mem_addr, '0);
    chk("midrst_dc_rdata", bus.o_riscv_arb_dc_rdata, '0);
    chk("midrst_dc_done", bus.o_riscv_arb_dc_done, 1'b0);
    beat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_mem_req", bus.o_riscv_arb_mem_req, 1'b0);
    end
    chk("postrst_dc_done_cnt", dc_done_cnt, 0);
    chk("postrst_ic_done_cnt", ic_done_cnt, 0);
    chk("postrst_dc_rdata", bus.o_riscv_arb_dc_rdata, '0);

    // Icache read with unaligned address, ready tied high
    stall_cfg = 0; stall_left = 0;
    bus.i_riscv_arb_ic_req  = 1'b1;
    bus.i_riscv_arb_ic_addr = 64'h1008;
    push_beat(64'h1000, 1'b0, '0, 64'hAAAA_0000);
    push_beat(64'h1008, 1'b0, '0, 64'hBBBB_0001);
    c0 = cyc;
    wait_done(1'b0, 10, "ic_done_timeout");
    bus.i_riscv_arb_ic_req = 1'b0;
    chk("ic_latency", ic_done_cyc - c0, 3);
    chk("ic_rdata", bus.o_riscv_arb_ic_rdata, {64'hBBBB_0001, 64'hAAAA_0000});
    repeat (4) tick();
    chk("ic_done_once", ic_done_cnt, 1);

    // Simultaneous requests: dcache first, icache two cycles after its done
    bus.i_riscv_arb_dc_req  = 1'b1;
    bus.i_riscv_arb_dc_we   = 1'b0;
    bus.i_riscv_arb_dc_addr = 64'h4010;
    bus.i_riscv_arb_ic_req  = 1'b1;
    bus.i_riscv_arb_ic_addr = 64'h5004;
    push_beat(64'h4010, 1'b0, '0, 64'h0D0D_0000_0000_0010);
    push_beat(64'h4018, 1'b0, '0, 64'h0D0D_0000_0000_0018);
    push_beat(64'h5000, 1'b0, '0, 64'h1C1C_0000_0000_5000);
    push_beat(64'h5008, 1'b0, '0, 64'h1C1C_0000_0000_5008);
    c0 = cyc;
    wait_done(1'b1, 10, "both_dc_done_timeout");
    bus.i_riscv_arb_dc_req = 1'b0;
    chk("both_dc_latency", dc_done_cyc - c0, 3);
    chk("both_ic_not_yet", ic_done_cnt, 1);
    exp_dc_line = {64'h0D0D_0000_0000_0018, 64'h0D0D_0000_0000_0010};
    chk("both_dc_rdata", bus.o_riscv_arb_dc_rdata, exp_dc_line);
    c1 = dc_done_cyc;
    wait_done(1'b0, 10, "both_ic_done_timeout");
    bus.i_riscv_arb_ic_req = 1'b0;
    chk("both_ic_gap", ic_done_cyc - c1, 4);
    chk("both_ic_rdata", bus.o_riscv_arb_ic_rdata, {64'h1C1C_0000_0000_5008, 64'h1C1C_0000_0000_5000});
    repeat (4) tick();
    chk("both_ic_done_cnt", ic_done_cnt, 2);
    chk("both_dc_done_cnt", dc_done_cnt, 1);

    // Dcache writeback with ready low for three cycles before each beat
    stall_cfg = 3; stall_left = 3;
    bus.i_riscv_arb_dc_req   = 1'b1;
    bus.i_riscv_arb_dc_we    = 1'b1;
    bus.i_riscv_arb_dc_addr  = 64'h2000;
    bus.i_riscv_arb_dc_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    push_beat(64'h2000, 1'b1, 64'h5555_6666_7777_8888, 64'hFFFF_FFFF_FFFF_FFFF);
    push_beat(64'h2008, 1'b1, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF);
    c0 = cyc;
    wait_done(1'b1, 40, "wb_done_timeout");
    bus.i_riscv_arb_dc_req = 1'b0;
    bus.i_riscv_arb_dc_we  = 1'b0;
    stall_cfg = 0; stall_left = 0;
    chk("wb_latency", dc_done_cyc - c0, 9);
    repeat (4) tick();
    chk("wb_done_once", dc_done_cnt, 2);
    chk("wb_dc_rdata_kept", bus.o_riscv_arb_dc_rdata, exp_dc_line);

    // Icache request dropped after beat 0 still completes
    bus.i_riscv_arb_ic_req  = 1'b1;
    bus.i_riscv_arb_ic_addr = 64'h6000;
    push_beat(64'h6000, 1'b0, '0, 64'h6666_0000_0000_0000);
    push_beat(64'h6008, 1'b0, '0, 64'h6666_0000_0000_0008);
    tick();
    bus.i_riscv_arb_ic_req = 1'b0;
    wait_done(1'b0, 10, "drop_done_timeout");
    chk("drop_ic_rdata", bus.o_riscv_arb_ic_rdata, {64'h6666_0000_0000_0008, 64'h6666_0000_0000_0000});
    chk("drop_dc_rdata_kept", bus.o_riscv_arb_dc_rdata, exp_dc_line);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_no_more_req", bus.o_riscv_arb_mem_req, 1'b0);
    end
    chk("drop_ic_done_cnt", ic_done_cnt, 3);
    chk("all_beats_consumed", beat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
